// File: rtl/al_queue_pkg.sv
// Shared types, constants and helpers for the active-list data queue.
// AL_DATA_QUEUE_PARITY_EN adds one even-parity bit to every stored entry.
package al_queue_pkg;

    localparam int ALQ_DEPTH = 128;

    typedef logic [$clog2(ALQ_DEPTH)-1:0] alq_ptr_t;
    typedef logic [$clog2(ALQ_DEPTH):0]   alq_cnt_t;

`ifdef AL_DATA_QUEUE_PARITY_EN
    localparam int ALQ_PARITY_BITS = 1;
`else
    localparam int ALQ_PARITY_BITS = 0;
`endif

    // Low bit of lane `lane` in a bus of `width`-bit lanes.
    function automatic int alq_lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/al_data_queue_ram.sv
// Multi-port entry storage: WPORT synchronous write lanes, RPORT asynchronous read lanes.
module al_data_queue_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8,
    parameter int WPORT = 4,
    parameter int RPORT = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic [WPORT-1:0]       we_i,
    input  logic [WPORT*AW-1:0]    waddr_i,
    input  logic [WPORT*WIDTH-1:0] wdata_i,
    input  logic [RPORT*AW-1:0]    raddr_i,
    output logic [RPORT*WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPORT; k++) begin
            if (we_i[k]) begin
                mem_q[waddr_i[k*AW +: AW]] <= wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar k = 0; k < RPORT; k++) begin : g_rd
        assign rdata_o[k*WIDTH +: WIDTH] = mem_q[raddr_i[k*AW +: AW]];
    end

endmodule

// File: rtl/al_data_queue.sv
// Circular active-list data queue: multi-lane push at tail, multi-lane pop at head.
// Build option AL_DATA_QUEUE_PARITY_EN enables per-entry parity and the sticky parity_err_o.
module al_data_queue
    import al_queue_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int INDEX = $clog2(DEPTH),
    parameter int WIDTH = 8,
    parameter int WPORT = 4,
    parameter int RPORT = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush_i,
    input  logic [$clog2(WPORT+1)-1:0]   push_cnt_i,
    input  logic [WPORT*WIDTH-1:0]       push_data_i,
    input  logic [$clog2(RPORT+1)-1:0]   pop_cnt_i,
    output logic [RPORT*WIDTH-1:0]       pop_data_o,
    output logic [RPORT-1:0]             pop_valid_o,
    output logic [INDEX-1:0]             head_o,
    output logic [INDEX-1:0]             tail_o,
    output logic [INDEX:0]               count_o,
    output logic [INDEX:0]               free_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         ovf_o,
    output logic                         unf_o,
    output logic                         parity_err_o
);

    localparam int SW = WIDTH + ALQ_PARITY_BITS;
    localparam int CW = INDEX + 1;

    logic [INDEX-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, perr_q, perr_d;
    logic [CW-1:0]      free_w, acc_push, acc_pop;
    logic               push_ok, pop_ok;

    logic [WPORT-1:0]       we;
    logic [WPORT*INDEX-1:0] waddr;
    logic [WPORT*SW-1:0]    wdata;
    logic [RPORT*INDEX-1:0] raddr;
    logic [RPORT*SW-1:0]    rdata;
    logic [RPORT-1:0]       lane_perr;

    assign free_w = CW'(DEPTH) - count_q;

    // Both directions are judged on the pre-cycle count, so a pop never makes room for a push.
    assign push_ok  = (int'(push_cnt_i) <= WPORT) && (int'(push_cnt_i) <= int'(free_w));
    assign pop_ok   = (int'(pop_cnt_i) <= RPORT) && (int'(pop_cnt_i) <= int'(count_q));
    assign acc_push = push_ok ? CW'(push_cnt_i) : '0;
    assign acc_pop  = pop_ok  ? CW'(pop_cnt_i)  : '0;

    for (genvar k = 0; k < WPORT; k++) begin : g_wr
        logic [WIDTH-1:0] lane_data;
        assign lane_data                 = push_data_i[alq_lane_lo(k, WIDTH) +: WIDTH];
        assign we[k]                     = push_ok && !flush_i && (k < int'(push_cnt_i));
        assign waddr[k*INDEX +: INDEX]   = tail_q + INDEX'(k);
`ifdef AL_DATA_QUEUE_PARITY_EN
        assign wdata[k*SW +: SW]         = {^lane_data, lane_data};
`else
        assign wdata[k*SW +: SW]         = lane_data;
`endif
    end

    for (genvar k = 0; k < RPORT; k++) begin : g_rd
        assign raddr[k*INDEX +: INDEX]              = head_q + INDEX'(k);
        assign pop_data_o[alq_lane_lo(k, WIDTH) +: WIDTH] = rdata[k*SW +: WIDTH];
        assign pop_valid_o[k]                       = int'(count_q) > k;
`ifdef AL_DATA_QUEUE_PARITY_EN
        assign lane_perr[k] = (^rdata[k*SW +: SW]) && (k < int'(pop_cnt_i));
`else
        assign lane_perr[k] = 1'b0;
`endif
    end

    al_data_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SW),
        .WPORT (WPORT),
        .RPORT (RPORT),
        .AW    (INDEX)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        perr_d  = perr_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            perr_d  = 1'b0;
        end else begin
            tail_d  = tail_q + acc_push[INDEX-1:0];
            head_d  = head_q + acc_pop[INDEX-1:0];
            count_d = count_q + acc_push - acc_pop;
            ovf_d   = !push_ok;
            unf_d   = !pop_ok;
            if (pop_ok) begin
                perr_d = perr_q | (|lane_perr);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            perr_q  <= perr_d;
        end
    end

    assign head_o       = head_q;
    assign tail_o       = tail_q;
    assign count_o      = count_q;
    assign free_o       = free_w;
    assign full_o       = (count_q == CW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign ovf_o        = ovf_q;
    assign unf_o        = unf_q;
    assign parity_err_o = perr_q;

endmodule

// File: tb/tb_al_data_queue.sv
// Scoreboard bench for al_data_queue: directed vectors queue expected post-edge state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_al_data_queue;

    localparam int DEPTH = 128;
    localparam int WIDTH = 8;
    localparam int WPORT = 4;
    localparam int RPORT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  push_cnt_i = '0;
    logic [31:0] push_data_i = '0;
    logic [2:0]  pop_cnt_i = '0;
    logic [31:0] pop_data_o;
    logic [3:0]  pop_valid_o;
    logic [6:0]  head_o, tail_o;
    logic [7:0]  count_o, free_o;
    logic        full_o, empty_o, ovf_o, unf_o, parity_err_o;

    typedef struct {
        string       tag;
        int          head;
        int          tail;
        int          count;
        bit          ovf;
        bit          unf;
        bit          perr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_perr = 1'b0;

    al_data_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .WPORT (WPORT),
        .RPORT (RPORT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .push_cnt_i   (push_cnt_i),
        .push_data_i  (push_data_i),
        .pop_cnt_i    (pop_cnt_i),
        .pop_data_o   (pop_data_o),
        .pop_valid_o  (pop_valid_o),
        .head_o       (head_o),
        .tail_o       (tail_o),
        .count_o      (count_o),
        .free_o       (free_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .ovf_o        (ovf_o),
        .unf_o        (unf_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    // Four consecutive byte lanes starting at value `base` (lane k = base+k).
    function automatic logic [31:0] lanes(input int base);
        return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
    endfunction

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input string tag, input int pc, input logic [31:0] pd,
                        input int oc, input bit fl,
                        input int eh, input int et, input int ec,
                        input bit eo, input bit eu, input logic [31:0] ed);
        exp_t e;
        push_cnt_i  = 3'(pc);
        push_data_i = pd;
        pop_cnt_i   = 3'(oc);
        flush_i     = fl;
        @(posedge clk);
        #1;
        push_cnt_i  = '0;
        push_data_i = '0;
        pop_cnt_i   = '0;
        flush_i     = 1'b0;
        e.tag   = tag;
        e.head  = eh;
        e.tail  = et;
        e.count = ec;
        e.ovf   = eo;
        e.unf   = eu;
        e.perr  = exp_perr;
        e.data  = ed;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [3:0]  vexp;
        logic [31:0] mask;
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            vexp = (e.count >= RPORT) ? 4'hF : 4'((1 << e.count) - 1);
            for (int k = 0; k < RPORT; k++) mask[k*8 +: 8] = {8{vexp[k]}};
            check(e.tag, "head",  32'(head_o),       32'(e.head));
            check(e.tag, "tail",  32'(tail_o),       32'(e.tail));
            check(e.tag, "count", 32'(count_o),      32'(e.count));
            check(e.tag, "free",  32'(free_o),       32'(DEPTH - e.count));
            check(e.tag, "full",  32'(full_o),       32'(e.count == DEPTH));
            check(e.tag, "empty", 32'(empty_o),      32'(e.count == 0));
            check(e.tag, "valid", 32'(pop_valid_o),  32'(vexp));
            check(e.tag, "ovf",   32'(ovf_o),        32'(e.ovf));
            check(e.tag, "unf",   32'(unf_o),        32'(e.unf));
            check(e.tag, "perr",  32'(parity_err_o), 32'(e.perr));
            if (e.count != 0) check(e.tag, "data", pop_data_o & mask, e.data & mask);
        end
    end

`ifdef AL_DATA_QUEUE_PARITY_EN
    logic [WIDTH:0] par_tmp;
`endif

    initial begin : stim
        // Reset, including a push presented while reset is held.
        step("rst0",     0, '0,        0, 0,   0, 0, 0, 0, 0, '0);
        step("rst_push", 4, lanes(0),  0, 0,   0, 0, 0, 0, 0, '0);
        reset_n = 1'b1;
        step("unf_empty", 0, '0, 1, 0,   0, 0, 0, 0, 1, '0);
        step("idle0",     0, '0, 0, 0,   0, 0, 0, 0, 0, '0);

        // Fill to full, then one rejected push.
        for (int i = 0; i < 32; i++)
            step("fill", 4, lanes(4*i), 0, 0, 0, (4*(i+1)) % DEPTH, 4*(i+1), 0, 0, lanes(0));
        step("ovf_full",  1, 32'hFF, 0, 0,   0, 0, 128, 1, 0, lanes(0));
        step("idle_full", 0, '0,     0, 0,   0, 0, 128, 0, 0, lanes(0));

        // Drain completely.
        for (int i = 0; i < 32; i++)
            step("drain", 0, '0, 4, 0, (4*(i+1)) % DEPTH, 0, 128 - 4*(i+1), 0, 0,
                 lanes((4*(i+1)) % DEPTH));

        // Stream push/pop together to walk the pointers up to 126.
        step("refill", 4, lanes(0), 0, 0,   0, 4, 4, 0, 0, lanes(0));
        for (int j = 1; j <= 30; j++)
            step("stream", 4, lanes(4*j), 4, 0, 4*j, 4 + 4*j, 4, 0, 0, lanes(4*j));
        step("p2q4", 2, lanes(124), 4, 0,   124, 126, 2, 0, 0, lanes(124));
        step("pop2", 0, '0,         2, 0,   126, 126, 0, 0, 0, '0);

        // Push across the DEPTH-1 -> 0 boundary.
        step("wrap",  4, 32'hA3A2A1A0, 0, 0,   126, 2, 4, 0, 0, 32'hA3A2A1A0);
        step("push5", 5, 32'hDEADBEEF, 0, 0,   126, 2, 4, 1, 0, 32'hA3A2A1A0);
        step("pop5",  0, '0,           5, 0,   126, 2, 4, 0, 1, 32'hA3A2A1A0);

        // Bring count to 127, then push 2 + pop 2: push rejected, pop accepted.
        for (int m = 0; m < 30; m++)
            step("to127", 4, lanes(2 + 4*m), 0, 0, 126, 6 + 4*m, 8 + 4*m, 0, 0, 32'hA3A2A1A0);
        step("to127", 3, lanes(122), 0, 0,   126, 125, 127, 0, 0, 32'hA3A2A1A0);
        step("sim",   2, lanes(125), 2, 0,   0, 125, 125, 1, 0, 32'h0302A3A2);

        // Pop down to 50, then flush with competing push/pop.
        for (int n = 0; n < 18; n++)
            step("to50", 0, '0, 4, 0, 4*(n+1), 125, 125 - 4*(n+1), 0, 0, lanes(4*(n+1)));
        step("to50",  0, '0,       3, 0,   75, 125, 50, 0, 0, lanes(75));
        step("flush", 4, lanes(0), 4, 1,   0, 0, 0, 0, 0, '0);
        step("post_flush", 0, '0,  0, 0,   0, 0, 0, 0, 0, '0);
        step("push1", 1, 32'h5A,   0, 0,   0, 1, 1, 0, 0, 32'h5A);
        step("pop1",  0, '0,       1, 0,   1, 1, 0, 0, 0, '0);

`ifdef AL_DATA_QUEUE_PARITY_EN
        // Corrupt entry head+1, pop two: sticky error until flush.
        step("par_push", 4, 32'h44332211, 0, 0,   1, 5, 4, 0, 0, 32'h44332211);
        par_tmp = dut.u_ram.mem_q[2];
        force dut.u_ram.mem_q[2] = par_tmp ^ 9'h001;
        exp_perr = 1'b1;
        step("par_pop",  0, '0, 2, 0,   3, 5, 2, 0, 0, 32'h00004433);
        release dut.u_ram.mem_q[2];
        step("par_hold", 0, '0, 0, 0,   3, 5, 2, 0, 0, 32'h00004433);
        exp_perr = 1'b0;
        step("par_flush", 0, '0, 0, 1,  0, 0, 0, 0, 0, '0);
`endif

        repeat (4) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
